// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Parity modes, TX FSM states and baud divisor function.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE,
    EVEN,
    ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT,
    GAP
  } tx_state_t;

  function automatic int baud_div(
    input int clock_rate,
    input int baud_rate
  );
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every DIV clocks.
// restart zeroes the count so a new frame gets a full first bit.
module uart_baud_tick #(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small frame FIFO in front.
// Frames leave the FIFO only while txEn is high.
module uart_tx_fifo
  import uart_pkg::parity_t;
  import uart_pkg::tx_state_t;
  import uart_pkg::baud_div;
  import uart_pkg::IDLE;
  import uart_pkg::START_BIT;
  import uart_pkg::PARITY_BIT;
  import uart_pkg::STOP_BIT;
  import uart_pkg::GAP;
#(
  parameter int      CLOCK_RATE   = 12000000,
  parameter int      BAUD_RATE    = 9600,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = uart_pkg::NONE,
  parameter int      STOP_BITS    = 1,
  parameter int      FIFO_DEPTH   = 4,
  parameter int      TURBO_FRAMES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        txEn,
  input  logic                        wrEn,
  input  logic [DATA_BITS-1:0]        in,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        txBusy,
  output logic                        txDone,
  output logic                        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE);
  localparam bit HAS_PAR = (PARITY != uart_pkg::NONE);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  tx_state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;

  logic tick;
  logic start;
  logic pop;
  logic push;
  logic last_stop;

  assign start = txEn && (level != '0);
  assign pop = (state_n == START_BIT) && (state != START_BIT);
  assign push = wrEn && (!full || pop);
  assign full = (level == DEPTH);
  assign last_stop = (state == STOP_BIT) && tick
                  && (stop_cnt == STOP_LAST);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk(clk),
    .reset(reset),
    .restart(pop),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      overflow <= wrEn && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txDone   <= 1'b0;
    end else begin
      txDone <= last_stop;
      // a turbo reload on the final stop tick wins over the stop count
      if (pop) begin
        shreg    <= mem[rd_ptr];
        par_bit  <= (PARITY == uart_pkg::ODD) ? ~(^mem[rd_ptr])
                                              : (^mem[rd_ptr]);
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else if (tick) begin
        if (state == uart_pkg::DATA_BITS) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == STOP_BIT) begin
          stop_cnt <= stop_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = START_BIT;
      end
      START_BIT: begin
        if (tick) state_n = uart_pkg::DATA_BITS;
      end
      uart_pkg::DATA_BITS: begin
        if (tick && bit_cnt == LAST_BIT) begin
          state_n = HAS_PAR ? PARITY_BIT : STOP_BIT;
        end
      end
      PARITY_BIT: begin
        if (tick) state_n = STOP_BIT;
      end
      STOP_BIT: begin
        if (last_stop) begin
          if (TURBO_FRAMES != 0) begin
            state_n = start ? START_BIT : IDLE;
          end else begin
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx     = 1'b1;
    txBusy = 1'b0;
    unique case (state)
      START_BIT: begin
        tx     = 1'b0;
        txBusy = 1'b1;
      end
      uart_pkg::DATA_BITS: begin
        tx     = shreg[0];
        txBusy = 1'b1;
      end
      PARITY_BIT: begin
        tx     = par_bit;
        txBusy = 1'b1;
      end
      STOP_BIT: begin
        txBusy = 1'b1;
      end
      default: begin
        tx     = 1'b1;
        txBusy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations, a FIFO vector
// table and a frame decoder checked against a scoreboard queue.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       wr [3];
  logic       en [3];
  logic       tx_a [3];
  logic       busy_a [3];
  logic       done_a [3];
  logic       full_a [3];
  logic       ovf_a [3];
  logic [2:0] lvl_a [3];

  always #5 clk = ~clk;

  // u0 defaults, u1 even parity, u2 odd parity + 2 stops + turbo
  uart_tx_fifo u0 (
    .clk(clk), .reset(reset), .txEn(en[0]), .wrEn(wr[0]),
    .in(din), .full(full_a[0]), .level(lvl_a[0]),
    .overflow(ovf_a[0]), .txBusy(busy_a[0]),
    .txDone(done_a[0]), .tx(tx_a[0])
  );

  uart_tx_fifo #(
    .CLOCK_RATE(8), .BAUD_RATE(1), .PARITY(EVEN)
  ) u1 (
    .clk(clk), .reset(reset), .txEn(en[1]), .wrEn(wr[1]),
    .in(din), .full(full_a[1]), .level(lvl_a[1]),
    .overflow(ovf_a[1]), .txBusy(busy_a[1]),
    .txDone(done_a[1]), .tx(tx_a[1])
  );

  uart_tx_fifo #(
    .CLOCK_RATE(8), .BAUD_RATE(1), .PARITY(ODD),
    .STOP_BITS(2), .TURBO_FRAMES(1)
  ) u2 (
    .clk(clk), .reset(reset), .txEn(en[2]), .wrEn(wr[2]),
    .in(din), .full(full_a[2]), .level(lvl_a[2]),
    .overflow(ovf_a[2]), .txBusy(busy_a[2]),
    .txDone(done_a[2]), .tx(tx_a[2])
  );

  int divs [3] = '{1250, 8, 8};
  int npar [3] = '{0, 1, 2};
  int nstop [3] = '{1, 1, 2};

  typedef struct {
    logic       wr;
    logic       en;
    logic [7:0] d;
    logic       acc;
    logic       full;
    int         lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl [7];
  logic [7:0] sb [$];
  int sel;
  int n_pass = 0;
  int n_tot = 0;
  int g;
  logic hold_ok;
  logic seen_done;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic exp_par(input logic [7:0] d, input int mode);
    return (mode == 2) ? ~(^d) : (^d);
  endfunction

  task automatic push(input int i, input logic [7:0] d);
    wr[i] = 1'b1;
    din = d;
    sb.push_back(d);
    @(negedge clk);
    wr[i] = 1'b0;
  endtask

  // Decode one frame of instance sel; gap = idle-high cycles before it.
  task automatic recv(input string tag, output int gap);
    int nb;
    int lim;
    int d;
    logic [12:0] bits;
    logic ok;
    logic [7:0] e;
    nb = 9 + ((npar[sel] != 0) ? 1 : 0) + nstop[sel];
    lim = 15 * divs[sel];
    gap = 0;
    bits = '0;
    while (tx_a[sel] !== 1'b0 && gap < lim) begin
      @(negedge clk);
      gap++;
    end
    if (tx_a[sel] !== 1'b0) begin
      n_tot++;
      $display("FAIL %s start: no start bit within %0d cycles", tag, lim);
      return;
    end
    ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < divs[sel]; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (k == 0) bits[b] = tx_a[sel];
        else if (tx_a[sel] !== bits[b]) ok = 1'b0;
        if (busy_a[sel] !== 1'b1) ok = 1'b0;
      end
    end
    chk({tag, " timing"}, int'(ok), 1);
    chk({tag, " start"}, int'(bits[0]), 0);
    d = int'(bits[8:1]);
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL %s extra: got frame %02h, none queued", tag, d);
    end else begin
      e = sb.pop_front();
      chk({tag, " data"}, d, int'(e));
      if (npar[sel] != 0) begin
        chk({tag, " parity"}, int'(bits[9]),
            int'(exp_par(e, npar[sel])));
      end
    end
    for (int s = 0; s < nstop[sel]; s++) begin
      chk({tag, " stop"}, int'(bits[nb-1-s]), 1);
    end
    @(negedge clk);
    chk({tag, " done"}, int'(done_a[sel]), 1);
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1, 1'b0},
      '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 2, 1'b0},
      '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 3, 1'b0},
      '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 4, 1'b0},
      '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 4, 1'b1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b0},
      '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 4, 1'b0}
    };
    reset = 1'b1;
    din = '0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0;
      en[i] = 1'b0;
    end
    sel = 0;
    repeat (3) @(negedge clk);

    chk("rst tx", int'(tx_a[0]), 1);
    chk("rst busy", int'(busy_a[0]), 0);
    chk("rst done", int'(done_a[0]), 0);
    chk("rst ovf", int'(ovf_a[0]), 0);
    chk("rst level", int'(lvl_a[0]), 0);
    chk("rst full", int'(full_a[0]), 0);
    reset = 1'b0;
    @(negedge clk);

    // default 8N1 timing and inter-frame gap
    sel = 0;
    push(0, 8'h7A);
    push(0, 8'h55);
    en[0] = 1'b1;
    recv("d0", g);
    recv("d1", g);
    // GAP period, plus possibly the IDLE dispatch cycle
    chk("d gap", int'(g >= 1250 && g <= 1251), 1);
    en[0] = 1'b0;

    // FIFO fill, overflow, push-with-pop while full
    sel = 1;
    foreach (tbl[r]) begin
      wr[1] = tbl[r].wr;
      en[1] = tbl[r].en;
      din = tbl[r].d;
      if (tbl[r].acc) sb.push_back(tbl[r].d);
      @(negedge clk);
      wr[1] = 1'b0;
      chk($sformatf("t%0d full", r), int'(full_a[1]), int'(tbl[r].full));
      chk($sformatf("t%0d level", r), int'(lvl_a[1]), tbl[r].lvl);
      chk($sformatf("t%0d ovf", r), int'(ovf_a[1]), int'(tbl[r].ovf));
    end
    for (int f = 0; f < 5; f++) begin
      recv($sformatf("q%0d", f), g);
      if (f != 0) chk("q gap", int'(g >= 8 && g <= 9), 1);
    end
    chk("q empty", int'(lvl_a[1]), 0);
    chk("q sb", sb.size(), 0);

    // drop txEn during data bit 3
    en[1] = 1'b0;
    push(1, 8'h7A);
    push(1, 8'hC3);
    fork
      recv("c0", g);
      begin
        int w;
        en[1] = 1'b1;
        w = 0;
        while (tx_a[1] !== 1'b0 && w < 50) begin
          @(negedge clk);
          w++;
        end
        repeat (35) @(negedge clk);
        en[1] = 1'b0;
      end
    join
    hold_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx_a[1] !== 1'b1 || busy_a[1] !== 1'b0) hold_ok = 1'b0;
    end
    chk("c hold", int'(hold_ok), 1);
    chk("c level", int'(lvl_a[1]), 1);
    en[1] = 1'b1;
    recv("c1", g);
    en[1] = 1'b0;

    // reset during data bit 4 with two words queued
    push(1, 8'hA1);
    push(1, 8'hA2);
    push(1, 8'hA3);
    en[1] = 1'b1;
    begin
      int w;
      w = 0;
      while (tx_a[1] !== 1'b0 && w < 50) begin
        @(negedge clk);
        w++;
      end
    end
    repeat (43) @(negedge clk);
    chk("r pre level", int'(lvl_a[1]), 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("r tx", int'(tx_a[1]), 1);
    chk("r level", int'(lvl_a[1]), 0);
    chk("r busy", int'(busy_a[1]), 0);
    seen_done = 1'b0;
    repeat (160) begin
      @(negedge clk);
      if (done_a[1] === 1'b1) seen_done = 1'b1;
    end
    chk("r no done", int'(seen_done), 0);
    push(1, 8'h5A);
    recv("r0", g);
    en[1] = 1'b0;

    // turbo: back-to-back frames, odd parity, two stop bits
    sel = 2;
    en[2] = 1'b1;
    push(2, 8'h7A);
    push(2, 8'hB1);
    recv("u0", g);
    recv("u1", g);
    chk("u gap", g, 0);
    en[2] = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
